// File: rtl/door_sequencer.sv
// door_sequencer: one elevator door cycle (open, dwell, close) counted in
// whole ticks of a slow time base. remain feeds a single-digit display.
// Optional feature macro: DOOR_REOPEN_EN -- when defined, a reopen condition
// during CLOSING sends the door back to OPENING; when undefined, obstruct
// freezes the closing phase until it clears.
module door_sequencer #(
   parameter logic [3:0] OPEN_TICKS  = 4'd2,
   parameter logic [3:0] DWELL_TICKS = 4'd5,
   parameter logic [3:0] CLOSE_TICKS = 4'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       arrive,
   input  logic       btn_open,
   input  logic       btn_close,
   input  logic       obstruct,
   output logic       motor_open,
   output logic       motor_close,
   output logic       door_closed,
   output logic [1:0] state,
   output logic [3:0] remain,
   output logic       cycle_done
);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cycle_done_q, cycle_done_d;
   logic       motor_open_q, motor_open_d;
   logic       motor_close_q, motor_close_d;
   logic       door_closed_q, door_closed_d;
   logic       frozen;

   // Next-state and counter logic; a reload or phase change swallows a
   // coincident tick, and the last tick of a phase (cnt<=1) always changes
   // phase so cnt never wraps below 1.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cycle_done_d = 1'b0;
      frozen       = 1'b0;
      case (state_q)
         CLOSED: begin
            if (arrive || btn_open) begin
               state_d = OPENING;
               cnt_d   = OPEN_TICKS;
            end
         end
         OPENING: begin
            if (tick) begin
               if (cnt_q <= 4'd1) begin
                  state_d = OPEN;
                  cnt_d   = DWELL_TICKS;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         OPEN: begin
            if (btn_open || obstruct) begin
               cnt_d = DWELL_TICKS;
            end else if (btn_close) begin
               state_d = CLOSING;
               cnt_d   = CLOSE_TICKS;
            end else if (tick) begin
               if (cnt_q <= 4'd1) begin
                  state_d = CLOSING;
                  cnt_d   = CLOSE_TICKS;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin // CLOSING
`ifdef DOOR_REOPEN_EN
            if (obstruct || btn_open || arrive) begin
               state_d = OPENING;
               cnt_d   = OPEN_TICKS;
            end else if (tick) begin
`else
            if (obstruct) begin
               frozen = 1'b1;
            end else if (tick) begin
`endif
               if (cnt_q <= 4'd1) begin
                  state_d      = CLOSED;
                  cnt_d        = 4'd0;
                  cycle_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
      endcase
   end

   // Output decode from the next state so outputs are registered and only
   // move on clk edges; motor_close drops while the close phase is frozen.
   always_comb begin
      motor_open_d  = (state_d == OPENING);
      motor_close_d = (state_d == CLOSING) && !frozen;
      door_closed_d = (state_d == CLOSED);
   end

   // State, counter and registered outputs with async active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= CLOSED;
         cnt_q         <= 4'd0;
         cycle_done_q  <= 1'b0;
         motor_open_q  <= 1'b0;
         motor_close_q <= 1'b0;
         door_closed_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cycle_done_q  <= cycle_done_d;
         motor_open_q  <= motor_open_d;
         motor_close_q <= motor_close_d;
         door_closed_q <= door_closed_d;
      end
   end

   assign state       = state_q;
   assign remain      = cnt_q;
   assign cycle_done  = cycle_done_q;
   assign motor_open  = motor_open_q;
   assign motor_close = motor_close_q;
   assign door_closed = door_closed_q;

endmodule
